// File: rtl/time_pkg.sv
// Shared types and constants for the time_chain clock/timer.
package time_pkg;

  localparam int FIELD_W = 8;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } mode_t;

  // Saturate a loaded field value to the field's maximum.
  function automatic logic [FIELD_W-1:0] clamp_field(input logic [FIELD_W-1:0] val,
                                                     input logic [FIELD_W-1:0] max);
    return (val > max) ? max : val;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Wrap-around 0..MAX counter with clear, clamped load, increment and decrement.
// carry/borrow are combinational so a chain of counters resolves in one edge.
module mod_counter
  import time_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               inc,
  input  logic               dec,
  input  logic               clr,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_val,
  output logic [FIELD_W-1:0] value,
  output logic               carry,
  output logic               borrow
);

  localparam logic [FIELD_W-1:0] MAX_V = FIELD_W'(MAX);

  logic [FIELD_W-1:0] value_reg, value_next;

  assign value  = value_reg;
  assign carry  = inc && (value_reg == MAX_V);
  assign borrow = dec && (value_reg == '0);

  // Next value: clear beats load beats increment beats decrement.
  always_comb begin
    value_next = value_reg;
    if (clr) begin
      value_next = '0;
    end else if (load) begin
      value_next = clamp_field(load_val, MAX_V);
    end else if (inc) begin
      value_next = (value_reg == MAX_V) ? '0 : value_reg + 1'b1;
    end else if (dec) begin
      value_next = (value_reg == '0) ? MAX_V : value_reg - 1'b1;
    end
  end

  // Value register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) value_reg <= '0;
    else       value_reg <= value_next;
  end

endmodule

// File: rtl/time_chain.sv
// hh:mm:ss clock with 1 s prescaler, set-mode FSM and synchronous load.
// Optional macro COUNTDOWN_EN adds down counting (up_down==0) with a
// zero_hit pulse and hold at 00:00:00; without it zero_hit is constant 0.
module time_chain
  import time_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int HOUR_MAX = 23
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               run_en,
  input  logic               up_down,
  input  logic               mode_btn,
  input  logic               inc_btn,
  input  logic               load,
  input  logic [FIELD_W-1:0] load_hh,
  input  logic [FIELD_W-1:0] load_mm,
  input  logic [FIELD_W-1:0] load_ss,
  output logic [FIELD_W-1:0] hh,
  output logic [FIELD_W-1:0] mm,
  output logic [FIELD_W-1:0] ss,
  output logic [1:0]         mode,
  output logic               tick_1hz,
  output logic               day_wrap,
  output logic               zero_hit
);

  localparam int PRE_W = $clog2(CLK_HZ);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);

  mode_t state_reg, state_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic tick_reg, tick_next, day_wrap_reg, day_wrap_next, zero_hit_reg, zero_hit_next;
  logic down, at_zero, tick_up, tick_dn, set_hh_inc, set_mm_inc, ss_clr;
  logic ss_carry, ss_borrow, mm_carry, mm_borrow, hh_carry, hh_borrow;

`ifdef COUNTDOWN_EN
  assign down = ~up_down;
`else
  logic unused_up_down;
  assign unused_up_down = up_down;
  assign down = 1'b0;
`endif

  assign at_zero    = (hh == '0) && (mm == '0) && (ss == '0);
  assign tick_up    = tick_next && !down;
  // Down counting freezes at 00:00:00, so no borrow ever leaves the all-zero value.
  assign tick_dn    = tick_next && down && !at_zero;
  assign set_hh_inc = !load && !mode_btn && inc_btn && (state_reg == SET_HH);
  assign set_mm_inc = !load && !mode_btn && inc_btn && (state_reg == SET_MM);
  assign ss_clr     = !load && mode_btn && (state_reg == RUN);

  // Set-mode FSM next state: load forces RUN, mode_btn steps the cycle.
  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = RUN;
    end else if (mode_btn) begin
      case (state_reg)
        RUN:     state_next = SET_HH;
        SET_HH:  state_next = SET_MM;
        default: state_next = RUN;
      endcase
    end
  end

  // Prescaler: cleared by load or leaving SET_MM, counts only in RUN with run_en.
  always_comb begin
    pre_next  = pre_reg;
    tick_next = 1'b0;
    if (load) begin
      pre_next = '0;
    end else if (mode_btn) begin
      if (state_reg == SET_MM) pre_next = '0;
    end else if ((state_reg == RUN) && run_en) begin
      if (pre_reg == PRE_LAST) begin
        pre_next  = '0;
        tick_next = 1'b1;
      end else begin
        pre_next = pre_reg + 1'b1;
      end
    end
  end

  // Event pulses derived from the chain; set-mode wraps never flag day_wrap.
  always_comb begin
    day_wrap_next = (tick_up && hh_carry) || hh_borrow;
`ifdef COUNTDOWN_EN
    zero_hit_next = tick_dn && (hh == '0) && (mm == '0) && (ss == FIELD_W'(1));
`else
    zero_hit_next = 1'b0;
`endif
  end

  // State, prescaler and registered pulse outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= RUN;
      pre_reg      <= '0;
      tick_reg     <= 1'b0;
      day_wrap_reg <= 1'b0;
      zero_hit_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pre_reg      <= pre_next;
      tick_reg     <= tick_next;
      day_wrap_reg <= day_wrap_next;
      zero_hit_reg <= zero_hit_next;
    end
  end

  mod_counter #(.MAX(SEC_MAX)) u_ss (
    .clock(clock), .reset(reset),
    .inc(tick_up), .dec(tick_dn), .clr(ss_clr), .load(load), .load_val(load_ss),
    .value(ss), .carry(ss_carry), .borrow(ss_borrow)
  );

  mod_counter #(.MAX(MIN_MAX)) u_mm (
    .clock(clock), .reset(reset),
    .inc((tick_up && ss_carry) || set_mm_inc), .dec(ss_borrow), .clr(1'b0),
    .load(load), .load_val(load_mm),
    .value(mm), .carry(mm_carry), .borrow(mm_borrow)
  );

  mod_counter #(.MAX(HOUR_MAX)) u_hh (
    .clock(clock), .reset(reset),
    .inc((tick_up && mm_carry) || set_hh_inc), .dec(mm_borrow), .clr(1'b0),
    .load(load), .load_val(load_hh),
    .value(hh), .carry(hh_carry), .borrow(hh_borrow)
  );

  assign mode     = state_reg;
  assign tick_1hz = tick_reg;
  assign day_wrap = day_wrap_reg;
  assign zero_hit = zero_hit_reg;

endmodule

// File: doc/time_chain.md
TIME_CHAIN -- requirements
Module: time_chain

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, clock cycles per 1 s tick (minimum 2).
REQ-002 SHALL have parameter HOUR_MAX, default 23, last hour value before wrap (minimum 1, maximum 99).
REQ-003 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port run_en  in  1  enables timebase and counting in RUN.
REQ-006 SHALL have port up_down  in  1  1 = count up, 0 = count down; ignored without COUNTDOWN_EN.
REQ-007 SHALL have port mode_btn  in  1  one-cycle pulse, advances set-mode FSM.
REQ-008 SHALL have port inc_btn  in  1  one-cycle pulse, increments the field selected by the FSM.
REQ-009 SHALL have port load  in  1  synchronous load of all fields.
REQ-010 SHALL have ports load_hh, load_mm, load_ss  in  8 each  load values, unsigned binary.
REQ-011 SHALL have ports hh, mm, ss  out  8 each  current time, unsigned binary.
REQ-012 SHALL have port mode  out  2  FSM state: 0 RUN, 1 SET_HH, 2 SET_MM.
REQ-013 SHALL have port tick_1hz  out  1  one-cycle pulse per timebase tick.
REQ-014 SHALL have port day_wrap  out  1  one-cycle pulse on hh wrap in either direction.
REQ-015 SHALL have port zero_hit  out  1  one-cycle pulse when countdown reaches 00:00:00.

Function
REQ-016 Priority SHALL be reset > load > mode_btn > inc_btn > tick counting.
REQ-017 Prescaler SHALL count 0..CLK_HZ-1 only when mode==RUN and run_en==1; otherwise it SHALL hold.
REQ-018 On the edge where prescaler==CLK_HZ-1 and counting is enabled, the prescaler SHALL go to 0, the fields SHALL update and tick_1hz SHALL be 1 for exactly the following cycle; zero latency beyond that edge.
REQ-019 Up count: ss 59->0 SHALL carry into mm; mm 59->0 SHALL carry into hh; hh HOUR_MAX->0 SHALL pulse day_wrap; all carries SHALL resolve on the same edge.
REQ-020 load SHALL write hh/mm/ss, clamping each value to its maximum (HOUR_MAX, 59, 59); it SHALL clear the prescaler and force mode to RUN.
REQ-021 FSM SHALL move RUN->SET_HH->SET_MM->RUN, one step per mode_btn.
REQ-022 Entering SET_HH SHALL clear ss to 0; leaving SET_MM SHALL clear the prescaler.
REQ-023 inc_btn in SET_HH SHALL increment hh, wrapping HOUR_MAX->0 with no day_wrap. In SET_MM it SHALL increment mm, wrapping 59->0 with no carry. In RUN it SHALL be ignored.
REQ-024 A simultaneous mode_btn and inc_btn SHALL apply only mode_btn.
REQ-025 Outputs tick_1hz, day_wrap and zero_hit SHALL be registered, never combinational.

Reset
REQ-026 Reset SHALL set hh=mm=ss=0, prescaler=0, mode=RUN, tick_1hz=day_wrap=zero_hit=0, at any time including mid-count or in a set mode.

Configuration
REQ-027 Macro COUNTDOWN_EN, when defined, SHALL enable down counting with up_down==0:
- ss 0->59 borrows from mm; mm 0->59 borrows from hh.
- hh 0->HOUR_MAX pulses day_wrap, but only when the value is not all-zero.
REQ-028 With COUNTDOWN_EN defined and down counting, a tick that produces 00:00:00 SHALL pulse zero_hit. At 00:00:00 further ticks SHALL hold the value with no pulses until load or up_down==1.
REQ-029 Without COUNTDOWN_EN, up_down SHALL be ignored, counting SHALL always be up and zero_hit SHALL be constant 0.

Structure
REQ-030 Package time_pkg SHALL hold the mode enum (RUN, SET_HH, SET_MM), SEC_MAX=59, MIN_MAX=59 and FIELD_W=8.
REQ-031 Sub-module mod_counter SHALL be used, instantiated three times:
- parameter MAX; inputs inc, dec, clr, load, load_val; outputs value, carry, borrow.
- wrap counter; carry/borrow combinational for chaining.

Verification (CLK_HZ=4, HOUR_MAX=23)
REQ-032 Reset release, run_en=1, 8 cycles -> tick_1hz on cycles 4 and 8, ss=2.
REQ-033 load 23:59:59, one tick -> 00:00:00, day_wrap=1 for one cycle, tick_1hz=1 same cycle.
REQ-034 mode_btn at ss=30 -> mode=1, ss=0. Then 25 inc_btn -> hh=1. Then mode_btn and 3 inc_btn -> mm+3. Then mode_btn -> mode=0, prescaler restarts from 0.
REQ-035 load 99:70:70 -> 23:59:59; reset asserted mid-prescaler -> all outputs 0 immediately (asynchronous).
REQ-036 COUNTDOWN_EN, up_down=0, load 00:00:02 -> after 2 ticks 00:00:00 with zero_hit once; 3 more ticks -> value held, no pulses.
